// File: rtl/latch_load_sequencer.sv
// Debounced push-button to D-latch load sequencer: synchronises BTN/DIN and emits one
// D-setup / EN-pulse / D-hold sequence per debounced press, counting accepted loads.
module latch_load_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_CYCLES    = 2
) (
    input  logic       CLK,
    input  logic       R,
    input  logic       BTN,
    input  logic       DIN,
    output logic       D,
    output logic       EN,
    output logic       BUSY,
    output logic [7:0] COUNT
);

    typedef enum logic [2:0] {
        StIdle,
        StPressDb,
        StSetup,
        StPulse,
        StHold,
        StWaitRel,
        StRelDb
    } state_e;

    localparam logic [15:0] DbLast    = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  PulseLast = 8'(PULSE_CYCLES - 1);

    logic [1:0]  btn_sync_q;
    logic [1:0]  din_sync_q;
    logic        btn_s;
    logic        din_s;

    state_e      state_q, state_d;
    logic [15:0] db_cnt_q, db_cnt_d;
    logic [7:0]  pulse_cnt_q, pulse_cnt_d;
    logic        d_q, d_d;
    logic        en_q, en_d;
    logic        busy_q, busy_d;
    logic [7:0]  count_q, count_d;

    assign btn_s = btn_sync_q[1];
    assign din_s = din_sync_q[1];

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            btn_sync_q <= 2'b00;
            din_sync_q <= 2'b00;
        end else begin
            btn_sync_q <= {btn_sync_q[0], BTN};
            din_sync_q <= {din_sync_q[0], DIN};
        end
    end

    always_comb begin
        state_d     = state_q;
        db_cnt_d    = db_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        d_d         = d_q;
        en_d        = en_q;
        count_d     = count_q;

        unique case (state_q)
            StIdle: begin
                en_d = 1'b0;
                if (btn_s) begin
                    state_d  = StPressDb;
                    db_cnt_d = '0;
                end
            end
            StPressDb: begin
                if (!btn_s) begin
                    state_d  = StIdle;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DbLast) begin
                    state_d = StSetup;
                    d_d     = din_s;
                end else begin
                    db_cnt_d = db_cnt_q + 16'd1;
                end
            end
            StSetup: begin
                state_d     = StPulse;
                en_d        = 1'b1;
                count_d     = count_q + 8'd1;
                pulse_cnt_d = '0;
            end
            StPulse: begin
                if (pulse_cnt_q == PulseLast) begin
                    state_d = StHold;
                    en_d    = 1'b0;
                end else begin
                    pulse_cnt_d = pulse_cnt_q + 8'd1;
                end
            end
            StHold: begin
                en_d    = 1'b0;
                state_d = StWaitRel;
            end
            StWaitRel: begin
                if (!btn_s) begin
                    state_d  = StRelDb;
                    db_cnt_d = '0;
                end
            end
            StRelDb: begin
                if (btn_s) begin
                    state_d  = StWaitRel;
                    db_cnt_d = '0;
                end else if (db_cnt_q == DbLast) begin
                    state_d = StIdle;
                end else begin
                    db_cnt_d = db_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
                en_d    = 1'b0;
            end
        endcase

        // Registered so BUSY is a clean flop output tracking the state register.
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            state_q     <= StIdle;
            db_cnt_q    <= '0;
            pulse_cnt_q <= '0;
            d_q         <= 1'b0;
            en_q        <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            db_cnt_q    <= db_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            d_q         <= d_d;
            en_q        <= en_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
        end
    end

    assign D     = d_q;
    assign EN    = en_q;
    assign BUSY  = busy_q;
    assign COUNT = count_q;

endmodule

// File: doc/latch_load_sequencer.md
Name: latch_load_sequencer

Overview:
- Upstream driver stage for the D-latch block: turns a raw, bouncy push-button (BTN) and data switch (DIN) into a clean, timed latch-load sequence on D and EN.
- Guarantees D is stable one cycle before EN rises and one cycle after EN falls. Each button press produces exactly one EN pulse.
- Counts accepted loads.
- D/EN connect directly to the latch D/EN inputs. R is shared with the latch reset.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronised cycles a level must hold to be accepted (1..65535).
- PULSE_CYCLES, 2, number of clock cycles EN is held high (1..255).

Ports:
- CLK  input  1  system clock, rising edge active.
- R  input  1  reset; asynchronous, active-low.
- BTN  input  1  raw push-button, asynchronous to CLK, active-high.
- DIN  input  1  raw data switch, asynchronous to CLK.
- D  output  1  data to latch, registered.
- EN  output  1  latch enable, registered, active-high.
- BUSY  output  1  high whenever the FSM is not in IDLE.
- COUNT  output  8  number of accepted loads, wraps.

Behaviour:
- Synchronisers: BTN and DIN each pass through a 2-flop synchroniser, giving BTN_s and DIN_s. Only the synchronised signals are used internally.
- Reset (R=0, asynchronous, overrides everything):
  - State=IDLE, debounce counter=0, pulse counter=0.
  - D=0, EN=0, BUSY=0, COUNT=0, synchroniser flops=0.
  - Asserting R mid-pulse drops EN immediately without waiting for a clock edge.
  - After R rises, the first action occurs on the next CLK edge.
- FSM states and transitions, evaluated on rising CLK:
  - IDLE: EN=0. If BTN_s=1, go to PRESS_DB and clear the debounce counter.
  - PRESS_DB: If BTN_s=0, go to IDLE (bounce rejected, no output change). Else if counter==DEBOUNCE_CYCLES-1, go to SETUP and capture D<=DIN_s. Else increment counter.
  - SETUP: one cycle, EN=0, D held. Go to PULSE; EN<=1; COUNT<=COUNT+1.
  - PULSE: EN=1 for exactly PULSE_CYCLES cycles. Then go to HOLD; EN<=0.
  - HOLD: one cycle, EN=0, D held. Go to WAIT_REL.
  - WAIT_REL: If BTN_s=0, go to REL_DB and clear the counter.
  - REL_DB: If BTN_s=1, go to WAIT_REL (release bounce). Else if counter==DEBOUNCE_CYCLES-1, go to IDLE. Else increment counter.
- Latency: with BTN high and stable from before edge 1, counting edges from the first edge that samples BTN=1:
  - D is captured at edge 3+DEBOUNCE_CYCLES.
  - EN rises at edge 4+DEBOUNCE_CYCLES.
  - EN falls at edge 4+DEBOUNCE_CYCLES+PULSE_CYCLES.
  - Defaults: D captured at edge 7; EN high from edge 8 to edge 10.
- D changes only at the SETUP-entry edge. D is never changed while EN=1 or in the cycles adjacent to EN=1.
- DIN changes outside the capture edge have no effect.
- A button held indefinitely produces one pulse only. A new load requires a debounced release, then a debounced press.
- COUNT increments at the edge EN rises. It wraps 255->0 with no flag.
- BUSY = (state != IDLE), registered alongside the state.
- Counter widths:
  - Debounce counter is 16 bits. It is cleared on every PRESS_DB/REL_DB entry and on any bounce.
  - Pulse counter is 8 bits.
- All outputs are glitch-free register outputs. No combinational path exists from BTN or DIN to any output.

Test Plan:
- Reset: R=0 with BTN=1, DIN=1 -> D=0, EN=0, BUSY=0, COUNT=0 with no clock edge. R=1 with BTN held -> one pulse with EN high at edge 8 (defaults).
- Clean load high: DIN=1, then BTN=1 for 20 cycles, then BTN=0 -> D=1 by edge 7, EN=1 for exactly 2 cycles (edges 8-10), D=1 thereafter, COUNT=1, BUSY=0 after release debounce.
- Bounce rejection: BTN toggles 1,0,1,0 every cycle for 8 cycles, then 0 -> EN never rises, COUNT stays 0, BUSY returns to 0.
- Latching low after high: load D=1, then DIN=0 and a second clean press -> D falls at the capture edge one cycle before EN rises, COUNT=2. A downstream latch model then holds 0.
- Stuck button and data stability: BTN held 100 cycles while DIN toggles every cycle -> exactly one EN pulse, COUNT=1, D constant from capture edge until the next press.
- Reset mid-pulse and wrap: assert R while EN=1 -> EN=0 asynchronously. Separately, 256 clean presses -> COUNT=0 after the 256th.
